// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM responder: command encoding, error codes,
// mode-register field positions and the command decoder.
package sdram_pkg;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_ACT,
    CMD_RD,
    CMD_WR,
    CMD_PRE,
    CMD_AREF,
    CMD_LMR
  } cmd_e;

  typedef enum logic {
    BANK_IDLE,
    BANK_ACTIVE
  } bank_state_e;

  localparam logic [2:0] ERR_NONE        = 3'd0;
  localparam logic [2:0] ERR_ACT_ACTIVE  = 3'd1;
  localparam logic [2:0] ERR_IDLE_ACCESS = 3'd2;
  localparam logic [2:0] ERR_BAD_LMR     = 3'd3;
  localparam logic [2:0] ERR_NOT_INIT    = 3'd4;
  localparam logic [2:0] ERR_REF_ACTIVE  = 3'd5;
  localparam logic [2:0] ERR_LANE        = 3'd6;

  localparam int MR_CL_LSB   = 4;
  localparam int MR_BL_LSB   = 0;
  localparam int PRE_ALL_BIT = 10;

  // Burst terminate (110) and deselect both collapse to NOP.
  function automatic cmd_e decode_cmd(input logic ncs, input logic nras,
                                      input logic ncas, input logic nwe);
    cmd_e c;
    c = CMD_NOP;
    if (!ncs) begin
      case ({nras, ncas, nwe})
        3'b011:  c = CMD_ACT;
        3'b101:  c = CMD_RD;
        3'b100:  c = CMD_WR;
        3'b010:  c = CMD_PRE;
        3'b001:  c = CMD_AREF;
        3'b000:  c = CMD_LMR;
        default: c = CMD_NOP;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/sdram_resp_bank.sv
// One SDRAM bank: IDLE/ACTIVE state plus the last latched row.
// The row register keeps its value through PRE so an idle access can reuse it.
module sdram_resp_bank
  import sdram_pkg::*;
#(
  parameter int ROW_BITS = 3
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_act,
  input  logic                i_pre,
  input  logic [ROW_BITS-1:0] i_row,
  output logic                o_active,
  output logic [ROW_BITS-1:0] o_row
);

  bank_state_e         r_state;
  bank_state_e         w_next;
  logic [ROW_BITS-1:0] r_row;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= BANK_IDLE;
      r_row   <= '0;
    end else begin
      r_state <= w_next;
      if (i_act) r_row <= i_row;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      BANK_IDLE:   if (i_act) w_next = BANK_ACTIVE;
      BANK_ACTIVE: if (i_pre) w_next = BANK_IDLE;
      default:     w_next = BANK_IDLE;
    endcase
  end

  assign o_active = (r_state == BANK_ACTIVE);
  assign o_row    = r_row;

endmodule

// File: rtl/sdram_responder.sv
// SDRAM device model answering the controller's command stream on the shared RD pins.
// Define SDRAM_RESP_CHECK_EN to enable the sticky protocol-error checker on ERR/ERRCODE.
module sdram_responder
  import sdram_pkg::*;
#(
  parameter int ROW_BITS = 3,
  parameter int COL_BITS = 9
) (
  input  logic       RCLK,
  input  logic       RESET,
  input  logic       CKE,
  input  logic       nCS,
  input  logic       nRAS,
  input  logic       nCAS,
  input  logic       nRWE,
  input  logic [1:0] RBA,
  input  logic [12:0] RA,
  input  logic       DQMH,
  input  logic       DQML,
  inout  wire  [7:0] RD,
  output logic       INITDONE,
  output logic       ERR,
  output logic [2:0] ERRCODE,
  output logic       o_dbg_rd_oe,
  output logic [3:0] o_dbg_bank_active
);

  localparam int AW = 2 + ROW_BITS + COL_BITS;

  logic                r_cke;
  logic [2:0]          r_cl;
  logic                r_initdone;
  logic [2:0]          r_pipe_v;
  logic [7:0]          r_pipe_d [3];
  logic [7:0]          r_mem_lo [2**AW];
  logic [7:0]          r_mem_hi [2**AW];

  cmd_e                w_cmd;
  logic [2:0]          w_code;
  logic [3:0]          w_bank_active;
  logic [ROW_BITS-1:0] w_bank_row [4];
  logic                w_lmr_ok;
  logic                w_access_ok;
  logic                w_do_act;
  logic                w_do_rd;
  logic                w_do_wr;
  logic                w_do_lmr;
  logic                w_do_pre;
  logic                w_rd_drive;
  logic [1:0]          w_ins_idx;
  logic [AW-1:0]       w_addr;
  logic [7:0]          w_rd_byte;
  logic                w_unused;

  // Pins are ignored on an edge whose preceding edge sampled CKE low.
  assign w_cmd    = r_cke ? decode_cmd(nCS, nRAS, nCAS, nRWE) : CMD_NOP;
  assign w_lmr_ok = ((RA[MR_CL_LSB+:3] == 3'd2) || (RA[MR_CL_LSB+:3] == 3'd3)) &&
                    (RA[MR_BL_LSB+:3] == 3'd0);

  always_comb begin
    w_code = ERR_NONE;
    case (w_cmd)
      CMD_ACT: begin
        if (!r_initdone)              w_code = ERR_NOT_INIT;
        else if (w_bank_active[RBA])  w_code = ERR_ACT_ACTIVE;
      end
      CMD_RD, CMD_WR: begin
        if (!r_initdone)              w_code = ERR_NOT_INIT;
        else if (!w_bank_active[RBA]) w_code = ERR_IDLE_ACCESS;
        else if (!DQMH && !DQML)      w_code = ERR_LANE;
      end
      CMD_LMR: begin
        if (|w_bank_active)           w_code = ERR_REF_ACTIVE;
        else if (!w_lmr_ok)           w_code = ERR_BAD_LMR;
      end
      CMD_AREF: if (|w_bank_active)   w_code = ERR_REF_ACTIVE;
      default: ;
    endcase
  end

`ifdef SDRAM_RESP_CHECK_EN
  assign w_access_ok = (w_code == ERR_NONE) || (w_code == ERR_LANE);
`else
  // Without the checker an access to an idle bank falls through to the stale row.
  assign w_access_ok = (w_code == ERR_NONE) || (w_code == ERR_LANE) ||
                       (w_code == ERR_IDLE_ACCESS);
`endif

  assign w_do_act = (w_cmd == CMD_ACT) && (w_code == ERR_NONE);
  assign w_do_rd  = (w_cmd == CMD_RD) && w_access_ok;
  assign w_do_wr  = (w_cmd == CMD_WR) && w_access_ok;
  assign w_do_lmr = (w_cmd == CMD_LMR) && (w_code == ERR_NONE);
  assign w_do_pre = (w_cmd == CMD_PRE);

  for (genvar b = 0; b < 4; b++) begin : g_bank
    sdram_resp_bank #(.ROW_BITS(ROW_BITS)) u_bank (
      .i_clk    (RCLK),
      .i_rst    (RESET),
      .i_act    (w_do_act && (RBA == b[1:0])),
      .i_pre    (w_do_pre && (RA[PRE_ALL_BIT] || (RBA == b[1:0]))),
      .i_row    (RA[ROW_BITS-1:0]),
      .o_active (w_bank_active[b]),
      .o_row    (w_bank_row[b])
    );
  end

  assign w_addr = {RBA, w_bank_row[RBA], RA[COL_BITS-1:0]};

  // With both lanes enabled only the low byte is written, matching the read side.
  always_ff @(posedge RCLK) begin
    if (w_do_wr) begin
      if (!DQML)         r_mem_lo[w_addr] <= RD;
      if (!DQMH && DQML) r_mem_hi[w_addr] <= RD;
    end
  end

  assign w_rd_byte  = !DQML ? r_mem_lo[w_addr] : r_mem_hi[w_addr];
  assign w_rd_drive = w_do_rd && !(DQML && DQMH);
  assign w_ins_idx  = (r_cl == 3'd3) ? 2'd2 : 2'd1;

  // Slot 0 drives the pins; a read enters at CL-1 and shifts down every edge.
  always_ff @(posedge RCLK or posedge RESET) begin
    if (RESET) begin
      r_pipe_v    <= '0;
      r_pipe_d[0] <= '0;
      r_pipe_d[1] <= '0;
      r_pipe_d[2] <= '0;
    end else begin
      r_pipe_v    <= {1'b0, r_pipe_v[2:1]};
      r_pipe_d[0] <= r_pipe_d[1];
      r_pipe_d[1] <= r_pipe_d[2];
      r_pipe_d[2] <= '0;
      if (w_rd_drive) begin
        r_pipe_v[w_ins_idx] <= 1'b1;
        r_pipe_d[w_ins_idx] <= w_rd_byte;
      end
    end
  end

  assign RD = r_pipe_v[0] ? r_pipe_d[0] : 8'hzz;

  always_ff @(posedge RCLK or posedge RESET) begin
    if (RESET) begin
      r_cke      <= 1'b1;
      r_cl       <= 3'd2;
      r_initdone <= 1'b0;
    end else begin
      r_cke <= CKE;
      if (w_do_lmr) begin
        r_cl       <= RA[MR_CL_LSB+:3];
        r_initdone <= 1'b1;
      end
    end
  end

`ifdef SDRAM_RESP_CHECK_EN
  logic       r_err;
  logic [2:0] r_errcode;

  always_ff @(posedge RCLK or posedge RESET) begin
    if (RESET) begin
      r_err     <= 1'b0;
      r_errcode <= ERR_NONE;
    end else if (!r_err && (w_code != ERR_NONE)) begin
      r_err     <= 1'b1;
      r_errcode <= w_code;
    end
  end

  assign ERR     = r_err;
  assign ERRCODE = r_errcode;
`else
  assign ERR     = 1'b0;
  assign ERRCODE = ERR_NONE;
`endif

  assign INITDONE          = r_initdone;
  assign o_dbg_rd_oe       = r_pipe_v[0];
  assign o_dbg_bank_active = w_bank_active;
  assign w_unused          = ^{RA[12:11], RA[9]};

endmodule
